// File: rtl/avr_div_pkg.sv
// Shared types and constants for the AVR iterative divider.
package avr_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_st_t;

  localparam int unsigned DIV_DW_DEF = 8;

  // Step counter width for a given operand width (at least one bit).
  function automatic int unsigned div_cnt_w(input int unsigned dw);
    return (dw <= 1) ? 1 : $clog2(dw);
  endfunction

  localparam int unsigned DIV_CNT_W_DEF = div_cnt_w(DIV_DW_DEF);

endpackage

// File: rtl/avr_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module avr_div_step #(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] prem_i,
  input  logic          dvd_msb_i,
  input  logic [DW-1:0] dvs_i,
  output logic [DW-1:0] prem_o,
  output logic          qbit_o
);

  logic [DW:0]   shifted;
  logic [DW+1:0] diff;

  // Shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    shifted = {prem_i, dvd_msb_i};
    diff    = {1'b0, shifted} - {2'b00, dvs_i};
    qbit_o  = ~diff[DW+1];
    // A kept result is below the divisor, and a restored one is below it too,
    // so both fit back into DW bits.
    prem_o  = qbit_o ? diff[DW-1:0] : shifted[DW-1:0];
  end

endmodule

// File: rtl/avr_div_seq.sv
// Iterative signed/unsigned divider; result packed as {remainder, quotient}.
module avr_div_seq
  import avr_div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW_DEF
) (
  input  logic            cp2,
  input  logic            ireset,
  input  logic            cp2en,
  input  logic            start,
  input  logic            divs,
  input  logic [DW-1:0]   rd_in,
  input  logic [DW-1:0]   rr_in,
  output logic [2*DW-1:0] dr_out,
  output logic            busy_out,
  output logic            done_out,
  output logic            dz_out,
  output logic            dv_out,
  output logic            mz_out
);

  localparam int unsigned CNT_W = div_cnt_w(DW);
  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  div_st_t            st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]      dvd_q, dvd_d;
  logic [DW-1:0]      dvs_q, dvs_d;
  logic [DW-1:0]      prem_q, prem_d;
  logic               sd_q, sd_d;
  logic               sr_q, sr_d;
  logic               ovf_q, ovf_d;
  logic [2*DW-1:0]    dr_q, dr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic               dv_q, dv_d;
  logic               mz_q, mz_d;

  logic [DW-1:0]      step_prem;
  logic               step_qbit;
  logic [DW-1:0]      quo, rem;

  avr_div_step #(.DW(DW)) u_step (
    .prem_i    (prem_q),
    .dvd_msb_i (dvd_q[DW-1]),
    .dvs_i     (dvs_q),
    .prem_o    (step_prem),
    .qbit_o    (step_qbit)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    prem_d = prem_q;
    sd_d   = sd_q;
    sr_d   = sr_q;
    ovf_d  = ovf_q;
    dr_d   = dr_q;
    dz_d   = dz_q;
    dv_d   = dv_q;
    mz_d   = mz_q;
    quo    = '0;
    rem    = '0;

    unique case (st_q)
      IDLE, DONE: begin
        if (start) begin
          sd_d   = divs & rd_in[DW-1];
          sr_d   = divs & rr_in[DW-1];
          ovf_d  = divs && (rd_in == MOST_NEG) && (rr_in == '1);
          dvs_d  = (divs && rr_in[DW-1]) ? (~rr_in + DW'(1)) : rr_in;
          // Divide-by-zero keeps the raw dividend for the remainder field.
          if (rr_in == '0)
            dvd_d = rd_in;
          else
            dvd_d = (divs && rd_in[DW-1]) ? (~rd_in + DW'(1)) : rd_in;
          prem_d = '0;
          cnt_d  = '0;
          dz_d   = 1'b0;
          dv_d   = 1'b0;
          mz_d   = 1'b0;
          st_d   = (rr_in == '0) ? FIX : ITER;
        end
      end
      ITER: begin
        dvd_d  = {dvd_q[DW-2:0], step_qbit};
        prem_d = step_prem;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DW-1))
          st_d = FIX;
      end
      FIX: begin
        if (dvs_q == '0) begin
          dr_d = {dvd_q, {DW{1'b1}}};
          dz_d = 1'b1;
          mz_d = 1'b0;
        end else if (ovf_q) begin
          dr_d = {{DW{1'b0}}, MOST_NEG};
          dv_d = 1'b1;
          mz_d = 1'b0;
        end else begin
          quo  = (sd_q ^ sr_q) ? (~dvd_q + DW'(1)) : dvd_q;
          rem  = sd_q ? (~prem_q + DW'(1)) : prem_q;
          dr_d = {rem, quo};
          mz_d = (quo == '0);
        end
        st_d = DONE;
      end
      default: st_d = IDLE;
    endcase

    busy_d = (st_d == ITER) || (st_d == FIX);
    done_d = (st_d == DONE);
  end

  // State and output registers; everything holds while cp2en is low.
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      sd_q   <= 1'b0;
      sr_q   <= 1'b0;
      ovf_q  <= 1'b0;
      dr_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      dv_q   <= 1'b0;
      mz_q   <= 1'b0;
    end else if (cp2en) begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      prem_q <= prem_d;
      sd_q   <= sd_d;
      sr_q   <= sr_d;
      ovf_q  <= ovf_d;
      dr_q   <= dr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q   <= dz_d;
      dv_q   <= dv_d;
      mz_q   <= mz_d;
    end
  end

  assign dr_out   = dr_q;
  assign busy_out = busy_q;
  assign done_out = done_q;
  assign dz_out   = dz_q;
  assign dv_out   = dv_q;
  assign mz_out   = mz_q;

endmodule

// File: doc/avr_div_seq.md
Name: avr_div_seq

Overview:
- Iterative 8-bit divider for the AVR core; the inverse companion of the core's 8x8 multiplier.
- Computes quotient and remainder for signed or unsigned operands.
- Uses one restoring step per enabled cp2 cycle, with a start/busy/done handshake toward the ALU/sequencer.
- Result is packed as {remainder, quotient}, matching the 16-bit multiplier result bus layout, so the register-pair writeback path is shared.

Parameters:
- DW, 8: operand width in bits. Quotient and remainder are each DW bits; the result bus is 2*DW bits.

Ports:
- cp2  input  1  core clock, rising-edge active
- ireset  input  1  reset, asynchronous, active-low
- cp2en  input  1  clock enable; all state advances only when it is 1
- start  input  1  request a division; sampled on an enabled edge
- divs  input  1  1 = signed (two's complement) operands, 0 = unsigned
- rd_in  input  DW  dividend
- rr_in  input  DW  divisor
- dr_out  output  2*DW  {remainder, quotient}
- busy_out  output  1  division in progress
- done_out  output  1  dr_out and flags valid
- dz_out  output  1  divide-by-zero flag
- dv_out  output  1  signed overflow flag (most-negative / -1)
- mz_out  output  1  quotient-is-zero flag

Behaviour:
- Reset (ireset=0, asynchronous) sets state IDLE and clears the counter, dr_out, all flags, busy_out and done_out. Reset asserted mid-operation aborts the division immediately; there is no resume.
- When cp2en=0, all registers hold, including state and counter.
- States: IDLE, ITER, FIX, DONE.
- IDLE or DONE with start=1 on an enabled edge:
  - Latch |rd_in| and |rr_in| (absolute values when divs=1) and the sign bits.
  - Clear the partial remainder and set the counter to 0.
  - Go to ITER, or to FIX directly if rr_in==0.
  - done_out drops on this edge.
- start is ignored in ITER and FIX; there is no queuing.
- ITER performs one restoring step per enabled edge:
  - Shift {prem, dividend} left by one.
  - Trial-subtract the divisor from prem. If the result is non-negative, prem takes the result and the new quotient bit is 1; otherwise prem is unchanged and the bit is 0.
  - After DW steps (counter==DW-1), go to FIX.
- FIX applies sign correction and then goes to DONE:
  - Signed: quotient is negated when the operand signs differ (truncation toward zero). Remainder takes the sign of the dividend.
  - Divide-by-zero: quotient is all ones, remainder = rd_in as latched (raw value), dz_out=1.
  - Signed most-negative / -1: quotient = most-negative value, remainder = 0, dv_out=1.
  - mz_out = (quotient==0).
- DONE: done_out=1 and outputs are held until the next accepted start. A start in DONE is accepted back-to-back.
- busy_out = 1 in ITER and FIX.
- Latency (normal): start accepted at enabled edge N; ITER occupies edges N+1..N+DW; FIX at N+DW+1, after which done_out=1. For DW=8 the result is valid after 9 further enabled edges.
- Latency (divide-by-zero): FIX at N+1, after which done_out=1 (1 further enabled edge).
- rd_in and rr_in may change after the start edge; only latched copies are used.
- Flags dz_out, dv_out and mz_out are updated only in FIX. They are cleared on an accepted start.

Decomposition:
- Package avr_div_pkg holds:
  - state enum div_st_t {IDLE, ITER, FIX, DONE}
  - constant DIV_DW_DEF=8
  - count width function/constant CNT_W = $clog2(DW)
- Sub-module avr_div_step: purely combinational single restoring step.
  - Inputs: prem, dividend MSB, divisor.
  - Outputs: next prem, quotient bit.
  - The FSM and registers stay in avr_div_seq.

Test Plan:
- Unsigned 200/7 (divs=0, rd=0xC8, rr=0x07) -> after 9 enabled edges done_out=1, dr_out=0x041C, dz=dv=mz=0; busy_out high exactly 9 enabled cycles.
- Signed -100/7 (rd=0x9C, rr=0x07, divs=1) -> dr_out=0xFEF2 (rem -2, quo -14). Also signed 100/-7 -> dr_out=0x02F2.
- Boundaries:
  - Signed 0x80/0xFF -> dr_out=0x0080, dv_out=1.
  - 0x55/0x00 (either mode) -> done after 1 enabled edge, dr_out=0x55FF, dz_out=1.
  - 3/9 unsigned -> dr_out=0x0300, mz_out=1.
- cp2en toggled pseudo-randomly during 200/7 -> identical result after exactly 9 enabled edges; start pulses during busy ignored; back-to-back start in DONE accepted with done_out falling on that edge.
- ireset pulsed low mid-ITER (count 4) -> all outputs 0 and state IDLE immediately without a clock; a following start for 255/16 -> dr_out=0x0F0F.
